// File: rtl/map_pkg.sv
// Shared types and constants for the map-lookup path between the DDA engines
// and the map BROM.
package map_pkg;

   localparam int MAP_N       = 24;
   localparam int MAP_ADDR_W  = $clog2(MAP_N * MAP_N);
   localparam int CLIENT_ID_W = 3;

   typedef logic [3:0] map_cell_t;

   // Out-of-range lookups read as solid wall.
   localparam map_cell_t OOB_DATA = 4'd1;

   typedef struct packed {
      logic                   valid;
      logic [CLIENT_ID_W-1:0] client_id;
      logic                   oob;
   } map_tag_t;

endpackage

// File: rtl/map_request_server_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index among eligible requesters,
// search starts at the client after the most recently granted one.
module rr_arbiter #(
   parameter  int NUM_CLIENTS = 4,
   localparam int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                   pixel_clk_in,
   input  logic                   rst_in,
   input  logic [NUM_CLIENTS-1:0] eligible,
   output logic [NUM_CLIENTS-1:0] grant,
   output logic [IDX_W-1:0]       grant_idx,
   output logic                   grant_valid
);

   logic [IDX_W-1:0] rr_ptr_reg;
   logic [IDX_W-1:0] rr_ptr_next;

   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         idx = int'(rr_ptr_reg) + i;
         if (idx >= NUM_CLIENTS) begin
            idx = idx - NUM_CLIENTS;
         end
         if (!grant_valid && eligible[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'(idx);
            grant[idx]  = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_valid) begin
         rr_ptr_next = (int'(grant_idx) == NUM_CLIENTS - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         rr_ptr_reg <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

endmodule

// File: rtl/map_request_server.sv
// Shares one map BRAM read port among several DDA engines: round-robin issue,
// fixed-latency tagged return with a one-hot valid strobe per engine.
module map_request_server
   import map_pkg::*;
#(
   parameter  int        NUM_CLIENTS  = 4,
   parameter  int        N            = MAP_N,
   parameter  int        BRAM_LATENCY = 2,
   parameter  map_cell_t OOB_DATA     = map_pkg::OOB_DATA,
   localparam int        ADDR_W       = $clog2(N * N)
) (
   input  logic                               pixel_clk_in,
   input  logic                               rst_in,
   input  logic [NUM_CLIENTS-1:0]             map_request_in,
   input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] map_addra_in,
   output map_cell_t                          map_data_out,
   output logic [NUM_CLIENTS-1:0]             map_data_valid_out,
   output logic [ADDR_W-1:0]                  bram_addr_out,
   input  map_cell_t                          bram_data_in
);

   localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int PIPE_D = BRAM_LATENCY + 1;

   logic [NUM_CLIENTS-1:0] pending_reg;
   logic [NUM_CLIENTS-1:0] valid_d_reg;
   logic [NUM_CLIENTS-1:0] eligible;
   logic [NUM_CLIENTS-1:0] grant;
   logic [NUM_CLIENTS-1:0] ret_onehot;
   logic [NUM_CLIENTS-1:0] map_data_valid_reg;
   logic [IDX_W-1:0]       grant_idx;
   logic                   grant_valid;
   logic [ADDR_W-1:0]      sel_addr;
   logic [ADDR_W-1:0]      bram_addr_reg;
   logic                   sel_oob;
   map_cell_t              map_data_reg;
   map_tag_t               tag_in;
   map_tag_t               tag_out;
   map_tag_t               tag_pipe_reg [PIPE_D];

   // pending stays set through the cycle after valid, hiding the stale held request.
   for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign eligible[gi]   = map_request_in[gi] & ~pending_reg[gi];
      assign ret_onehot[gi] = tag_out.valid && (tag_out.client_id == CLIENT_ID_W'(gi));
   end

   rr_arbiter #(
      .NUM_CLIENTS (NUM_CLIENTS)
   ) u_rr_arbiter (
      .pixel_clk_in (pixel_clk_in),
      .rst_in       (rst_in),
      .eligible     (eligible),
      .grant        (grant),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid)
   );

   assign sel_addr = map_addra_in[grant_idx];
   assign sel_oob  = int'(sel_addr) >= N * N;
   assign tag_in   = '{valid: grant_valid, client_id: CLIENT_ID_W'(grant_idx), oob: sel_oob & grant_valid};
   assign tag_out  = tag_pipe_reg[PIPE_D-1];

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         pending_reg        <= '0;
         valid_d_reg        <= '0;
         bram_addr_reg      <= '0;
         map_data_reg       <= '0;
         map_data_valid_reg <= '0;
         for (int i = 0; i < PIPE_D; i++) begin
            tag_pipe_reg[i] <= '0;
         end
      end else begin
         pending_reg        <= (pending_reg & ~valid_d_reg) | grant;
         valid_d_reg        <= map_data_valid_reg;
         map_data_valid_reg <= ret_onehot;
         if (grant_valid) begin
            bram_addr_reg <= sel_oob ? '0 : sel_addr;
         end
         tag_pipe_reg[0] <= tag_in;
         for (int i = 1; i < PIPE_D; i++) begin
            tag_pipe_reg[i] <= tag_pipe_reg[i-1];
         end
         if (tag_out.valid) begin
            map_data_reg <= tag_out.oob ? OOB_DATA : bram_data_in;
         end
      end
   end

   assign map_data_out       = map_data_reg;
   assign map_data_valid_out = map_data_valid_reg;
   assign bram_addr_out      = bram_addr_reg;

endmodule

// File: tb/tb_map_request_server.sv
// Scoreboard bench for map_request_server: behavioural clients, 2-cycle BRAM
// model, expected responses queued at request time and matched on each strobe.
module tb_map_request_server;
   import map_pkg::*;

   localparam int NC   = 4;
   localparam int AW   = 10;
   localparam int NN   = 576;

   typedef struct {
      int client;
      int data;
      int cyc;
   } exp_t;

   logic                   pixel_clk_in = 1'b0;
   logic                   rst_in;
   logic [NC-1:0]          map_request_in;
   logic [NC-1:0][AW-1:0]  map_addra_in;
   map_cell_t              map_data_out;
   logic [NC-1:0]          map_data_valid_out;
   logic [AW-1:0]          bram_addr_out;
   map_cell_t              bram_data_in;

   map_cell_t mem [1024];
   map_cell_t rd_d1, rd_d2;

   int     cyc;
   int     checks;
   int     errors;
   exp_t   sb_q [$];
   bit     cl_active   [NC];
   bit     cl_hold     [NC];
   bit     cl_dropping [NC];
   int     cl_remaining[NC];
   logic [NC-1:0] seen_valid;

   map_request_server dut (
      .pixel_clk_in       (pixel_clk_in),
      .rst_in             (rst_in),
      .map_request_in     (map_request_in),
      .map_addra_in       (map_addra_in),
      .map_data_out       (map_data_out),
      .map_data_valid_out (map_data_valid_out),
      .bram_addr_out      (bram_addr_out),
      .bram_data_in       (bram_data_in)
   );

   always #5 pixel_clk_in = ~pixel_clk_in;

   // Map BROM with two cycles from address to data.
   always @(posedge pixel_clk_in) begin
      rd_d1 <= mem[bram_addr_out];
      rd_d2 <= rd_d1;
   end
   assign bram_data_in = rd_d2;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("FAIL %s: observed %0d required %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic int exp_data(input int addr);
      if (addr >= NN) return int'(OOB_DATA);
      return int'(mem[addr]);
   endfunction

   function automatic int active_count();
      int n = 0;
      for (int k = 0; k < NC; k++) n += int'(cl_active[k]);
      return n;
   endfunction

   task automatic monitor();
      exp_t e;
      seen_valid = rst_in ? '0 : map_data_valid_out;
      if (!rst_in && map_data_valid_out != '0) begin
         check("valid_onehot", $countones(map_data_valid_out), 1);
         if (sb_q.size() == 0) begin
            check("unexpected_valid", int'(map_data_valid_out), 0);
         end else begin
            e = sb_q.pop_front();
            $display("cycle %0d: response valid=%b data=%0d (expect client %0d data %0d)",
                     cyc, map_data_valid_out, map_data_out, e.client, e.data);
            check("resp_client", int'(map_data_valid_out), 1 << e.client);
            check("resp_data", int'(map_data_out), e.data);
            if (e.cyc >= 0) check("resp_cycle", cyc, e.cyc);
         end
      end
   endtask

   task automatic service_clients();
      for (int k = 0; k < NC; k++) begin
         if (cl_dropping[k]) begin
            map_request_in[k] = 1'b0;
            cl_active[k]      = 1'b0;
            cl_dropping[k]    = 1'b0;
         end else if (cl_active[k] && seen_valid[k]) begin
            if (cl_remaining[k] > 0) begin
               cl_remaining[k]--;
               map_addra_in[k] = map_addra_in[k] + 1'b1;
               sb_q.push_back(exp_t'{client: k, data: exp_data(int'(map_addra_in[k])), cyc: -1});
            end else if (cl_hold[k]) begin
               cl_dropping[k] = 1'b1;
            end else begin
               map_request_in[k] = 1'b0;
               cl_active[k]      = 1'b0;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge pixel_clk_in);
      monitor();
      @(posedge pixel_clk_in);
      cyc++;
      #1;
      service_clients();
   endtask

   task automatic launch(input int k, input int addr, input int rem, input bit hold, input int exp_cyc);
      map_request_in[k] = 1'b1;
      map_addra_in[k]   = AW'(addr);
      cl_active[k]      = 1'b1;
      cl_remaining[k]   = rem;
      cl_hold[k]        = hold;
      cl_dropping[k]    = 1'b0;
      sb_q.push_back(exp_t'{client: k, data: exp_data(addr), cyc: exp_cyc});
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || active_count() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         check("drain_pending", sb_q.size() + active_count(), 0);
         sb_q.delete();
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, int'(map_data_valid_out), 0);
      check({tag, "_data"}, int'(map_data_out), 0);
      check({tag, "_bram_addr"}, int'(bram_addr_out), 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int i = 0; i < 1024; i++) mem[i] = map_cell_t'(i * 7 + 3);
      mem[5] = 4'd3;
      map_request_in = '0;
      map_addra_in   = '0;
      seen_valid     = '0;
      for (int k = 0; k < NC; k++) begin
         cl_active[k] = 0; cl_hold[k] = 0; cl_dropping[k] = 0; cl_remaining[k] = 0;
      end

      // Reset state
      rst_in = 1'b1;
      repeat (3) tick();
      check_outputs_zero("reset");
      rst_in = 1'b0;

      // Single request
      tick();
      launch(0, 5, 0, 1'b0, cyc + 4);
      tick();
      check("single_bram_addr", int'(bram_addr_out), 5);
      drain(30);

      // Simultaneous requests from a freshly reset pointer
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      for (int k = 0; k < NC; k++) launch(k, 10 + k, 0, 1'b0, cyc + 4 + k);
      for (int i = 0; i < NC; i++) begin
         tick();
         check("simul_bram_addr", int'(bram_addr_out), 10 + i);
      end
      drain(30);

      // Fairness: two clients re-requesting continuously
      launch(0, 100, 5, 1'b0, -1);
      launch(1, 200, 5, 1'b0, -1);
      drain(200);

      // Out-of-range address
      launch(2, 600, 0, 1'b0, cyc + 4);
      tick();
      check("oob_bram_addr", int'(bram_addr_out), 0);
      drain(30);

      // Reset two cycles after a grant; the held request is re-served afterwards
      map_request_in[3] = 1'b1;
      map_addra_in[3]   = AW'(50);
      cl_active[3]      = 1'b1;
      cl_remaining[3]   = 0;
      cl_hold[3]        = 1'b0;
      tick();
      tick();
      rst_in = 1'b1;
      tick();
      check_outputs_zero("midreset");
      rst_in = 1'b0;
      sb_q.push_back(exp_t'{client: 3, data: exp_data(50), cyc: cyc + 4});
      drain(30);

      // Request held one cycle past valid must not be granted again
      launch(2, 300, 0, 1'b1, cyc + 4);
      drain(30);
      repeat (8) tick();
      check("final_queue_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
